rs_multi_cdb: RTL and testbench
===============================

# rs_multi_cdb

Parametrised reservation station sitting between ROB dispatch and the execute unit. It holds up to `DEPTH` in-flight instructions and wakes up pending operands from `CDB_N` common-data-bus broadcasts (EX, LSB, and future units). It issues one ready instruction per cycle through a registered valid/ready output stage, and supports pipeline flush and occupancy reporting.

## Interface
Parameters:
- `DEPTH`, 16: number of entries; power of two, ≥2.
- `DATA_W`, 32: operand / pc / imm width.
- `TAG_W`, 5: ROB tag width; tag 0 means "value present".
- `OP_W`, 6: opcode width.
- `CDB_N`, 2: number of broadcast ports.

Ports:
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `en`  in  1: global stall; low freezes all state.
- `flush`  in  1: discard all entries and the output stage.
- `in_valid`  in  1: dispatch request.
- `in_ready`  out  1: entry available (`count < DEPTH`) and `en` high.
- `in_op` / `in_pc` / `in_imm`  in  `OP_W` / `DATA_W` / `DATA_W`: instruction fields.
- `in_qs1`, `in_qs2`  in  `TAG_W`: source tags.
- `in_vs1`, `in_vs2`  in  `DATA_W`: source values, valid when the matching tag is 0.
- `in_qd`  in  `TAG_W`: destination ROB tag.
- `out_valid`  out  1: issue stage holds an instruction.
- `out_ready`  in  1: EX accepts.
- `out_op` / `out_pc` / `out_imm` / `out_vs1` / `out_vs2` / `out_qd`  out: issued fields, registered.
- `cdb_valid`  in  `CDB_N`: broadcast valid per port.
- `cdb_tag`  in  `CDB_N*TAG_W`: packed, port 0 in the LSBs.
- `cdb_data`  in  `CDB_N*DATA_W`: packed, port 0 in the LSBs.
- `count`  out  `$clog2(DEPTH)+1`: occupied entries, excluding the output stage.

## Operation
- Reset (`rst` low, async): all entries free, `count`=0, `out_valid`=0, all out_* data=0.
- Dispatch: a transfer occurs when `in_valid && in_ready` at the edge. The lowest-index free entry is written.
- Dispatch-time bypass: if `in_qs1`/`in_qs2` matches a valid, nonzero CDB tag in the same cycle, the entry stores that CDB data with the tag cleared.
- Wakeup: each valid CDB port with a nonzero tag clears every matching `qs1`/`qs2` and writes its data. If several ports carry the same tag, the lowest port index wins. CDB tag 0 is ignored.
- Ready entry: occupied, `qs1==0`, `qs2==0`.
- Selection: one ready entry per cycle, chosen by the `rs_select` policy (see Configuration).
- Issue stage load: allowed when the stage is empty (`!out_valid`) or draining (`out_valid && out_ready`). The selected entry moves into the stage and is freed at the same edge.
- Draining with no ready entry leaves `out_valid`=0.
- Simultaneous dispatch and issue: both occur; `count` is unchanged.
- Full (`count==DEPTH`): `in_ready`=0. A same-cycle issue does not reopen `in_ready` that cycle.
- `flush` (sampled when `en` high): at the next edge all entries are freed, `count`=0 and `out_valid`=0. Flush dominates dispatch, issue and wakeup. An `out_valid && out_ready` transfer in the flush cycle still counts as accepted by EX.
- `en` low: no state changes. `in_ready`=0. Outputs hold. CDB broadcasts in that cycle are lost; the producers stall on the same `en`.

## Timing
- Dispatch with both operands ready at edge E0: selectable in the cycle after E0, loaded at E1, `out_valid` high after E1. Minimum dispatch-to-issue latency is 1 cycle.
- Wakeup at edge E: the entry is selectable only in the cycle after E. There is no same-cycle wakeup-to-select path.
- `out_*` are pure flop outputs. `in_ready` and `count` are flop-derived, with no combinational path from `in_valid`.
- Throughput: 1 issue/cycle while `out_ready` is held high.

## Configuration
- `RS_AGE_SELECT_EN` defined:
  - An age matrix (`DEPTH×DEPTH` bits) records dispatch order.
  - Selection picks the oldest ready entry.
  - On dispatch, the new entry is marked younger than all occupied entries.
- Not defined:
  - Selection picks the lowest-index ready entry.
  - No age state is built.

## Structure
- Package `rs_pkg`:
  - `rs_entry_t` struct holding `op`, `pc`, `imm`, `qs1`, `qs2`, `vs1`, `vs2`, `qd`, `busy`.
  - `TAG_NONE` = 0.
  - Default widths for `DATA_W`, `TAG_W` and `OP_W`.
- Sub-module `rs_select`:
  - Inputs: ready vector, plus the age matrix when `RS_AGE_SELECT_EN` is defined.
  - Outputs: one-hot grant and grant index.
  - Reused for free-entry search with the lowest-index policy.

## Test plan
- Reset mid-operation: 3 entries occupied and `out_valid`=1, drop `rst` asynchronously → `out_valid`=0 and `count`=0 immediately, before the next edge.
- Back-to-back ready dispatch: 4 entries with tags 0, `out_ready`=1 → `out_valid` from cycle 2, qd 1,2,3,4 in order, `count` returns to 0.
- Dual-CDB wakeup: entry waits on `qs1`=3 and `qs2`=7; port0 sends tag 3 data 0x11 and port1 sends tag 7 data 0x22 in the same cycle → issued next cycle with `vs1`=0x11, `vs2`=0x22.
- Dispatch bypass and full: dispatch `qs1`=5 while CDB carries tag 5 data 0xAB → entry ready immediately. Then fill `DEPTH` entries with an unready tag → `in_ready`=0 and an extra `in_valid` is ignored.
- Age order (`RS_AGE_SELECT_EN`): dispatch A into slot 2 then B into slot 0, wake both together → A issues first. With the macro undefined → B issues first.
- Flush and backpressure: `out_ready`=0 with `out_valid`=1 → outputs stable. Assert `flush` → `out_valid`=0, `count`=0, and a dispatch in the flush cycle is dropped.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared types and default widths for the multi-CDB reservation station.
// Build option: RS_AGE_SELECT_EN selects oldest-ready issue instead of lowest-index.
package rs_pkg;
    localparam int RS_DATA_W = 32;
    localparam int RS_TAG_W  = 5;
    localparam int RS_OP_W   = 6;

    // Tag 0 means the operand value is already present.
    localparam logic [RS_TAG_W-1:0] TAG_NONE = '0;

    typedef struct packed {
        logic [RS_OP_W-1:0]   op;
        logic [RS_DATA_W-1:0] pc;
        logic [RS_DATA_W-1:0] imm;
        logic [RS_TAG_W-1:0]  qs1;
        logic [RS_TAG_W-1:0]  qs2;
        logic [RS_DATA_W-1:0] vs1;
        logic [RS_DATA_W-1:0] vs2;
        logic [RS_TAG_W-1:0]  qd;
        logic                 busy;
    } rs_entry_t;

    typedef struct packed {
        logic [RS_OP_W-1:0]   op;
        logic [RS_DATA_W-1:0] pc;
        logic [RS_DATA_W-1:0] imm;
        logic [RS_DATA_W-1:0] vs1;
        logic [RS_DATA_W-1:0] vs2;
        logic [RS_TAG_W-1:0]  qd;
    } rs_issue_t;
endpackage

// File: rtl/rs_multi_cdb_if.sv
// Dispatch, issue and CDB bundle of the reservation station; slave is the RS side.
interface rs_multi_cdb_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5,
    parameter int OP_W   = 6,
    parameter int CDB_N  = 2
);
    logic                    in_valid;
    logic                    in_ready;
    logic [OP_W-1:0]         in_op;
    logic [DATA_W-1:0]       in_pc;
    logic [DATA_W-1:0]       in_imm;
    logic [TAG_W-1:0]        in_qs1;
    logic [TAG_W-1:0]        in_qs2;
    logic [DATA_W-1:0]       in_vs1;
    logic [DATA_W-1:0]       in_vs2;
    logic [TAG_W-1:0]        in_qd;
    logic                    out_valid;
    logic                    out_ready;
    logic [OP_W-1:0]         out_op;
    logic [DATA_W-1:0]       out_pc;
    logic [DATA_W-1:0]       out_imm;
    logic [DATA_W-1:0]       out_vs1;
    logic [DATA_W-1:0]       out_vs2;
    logic [TAG_W-1:0]        out_qd;
    logic [CDB_N-1:0]        cdb_valid;
    logic [CDB_N*TAG_W-1:0]  cdb_tag;
    logic [CDB_N*DATA_W-1:0] cdb_data;

    modport master (
        output in_valid, in_op, in_pc, in_imm, in_qs1, in_qs2, in_vs1, in_vs2, in_qd,
        input  in_ready,
        input  out_valid, out_op, out_pc, out_imm, out_vs1, out_vs2, out_qd,
        output out_ready,
        output cdb_valid, cdb_tag, cdb_data
    );
    modport slave (
        input  in_valid, in_op, in_pc, in_imm, in_qs1, in_qs2, in_vs1, in_vs2, in_qd,
        output in_ready,
        output out_valid, out_op, out_pc, out_imm, out_vs1, out_vs2, out_qd,
        input  out_ready,
        input  cdb_valid, cdb_tag, cdb_data
    );
endinterface

// File: rtl/rs_select.sv
// One-hot picker: oldest requester via age matrix (RS_AGE_SELECT_EN) or lowest index.
module rs_select #(
    parameter int DEPTH = 16
) (
    input  logic [DEPTH-1:0]             req,
`ifdef RS_AGE_SELECT_EN
    input  logic [DEPTH-1:0][DEPTH-1:0]  age,
`endif
    output logic [DEPTH-1:0]             gnt,
    output logic [$clog2(DEPTH)-1:0]     idx
);
    localparam int IW = $clog2(DEPTH);

    logic [DEPTH-1:0] blk;

    // age[j][i] set means entry j is older than entry i.
    always_comb begin
        blk = '0;
        gnt = '0;
        idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
`ifdef RS_AGE_SELECT_EN
                if (req[j] && age[j][i]) blk[i] = 1'b1;
`else
                if (j < i && req[j]) blk[i] = 1'b1;
`endif
            end
            gnt[i] = req[i] && !blk[i];
            if (gnt[i]) idx = idx | IW'(i);
        end
    end
endmodule

// File: rtl/rs_multi_cdb.sv
// Reservation station with CDB_N wakeup ports and a registered issue stage.
// Build option: RS_AGE_SELECT_EN enables oldest-ready selection via an age matrix.
module rs_multi_cdb
    import rs_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = RS_DATA_W,
    parameter int TAG_W  = RS_TAG_W,
    parameter int OP_W   = RS_OP_W,
    parameter int CDB_N  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   flush,
    rs_multi_cdb_if.slave          bus,
    output logic [$clog2(DEPTH):0] count
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    rs_entry_t        ent_q [DEPTH];
    rs_entry_t        ent_d [DEPTH];
    rs_entry_t        new_e;
    rs_issue_t        out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] free_vec, rdy_vec, free_gnt, sel_gnt;
    logic [IW-1:0]    free_idx, sel_idx;
    logic             sel_any, do_disp, do_load;
    logic [DATA_W:0]  m1, m2, nm1, nm2;

    logic [CDB_N-1:0]        cdb_v;
    logic [CDB_N*TAG_W-1:0]  cdb_t;
    logic [CDB_N*DATA_W-1:0] cdb_dt;
    assign cdb_v  = bus.cdb_valid;
    assign cdb_t  = bus.cdb_tag;
    assign cdb_dt = bus.cdb_data;

    // Returns {hit, data}; walking down from the top lets port 0 win on tag clashes.
    function automatic logic [DATA_W:0] cdb_match(input logic [TAG_W-1:0] tag);
        cdb_match = '0;
        for (int p = CDB_N - 1; p >= 0; p--)
            if (cdb_v[p] && cdb_t[p*TAG_W +: TAG_W] != TAG_NONE && cdb_t[p*TAG_W +: TAG_W] == tag)
                cdb_match = {1'b1, cdb_dt[p*DATA_W +: DATA_W]};
    endfunction

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            free_vec[i] = !ent_q[i].busy;
            rdy_vec[i]  = ent_q[i].busy && ent_q[i].qs1 == TAG_NONE && ent_q[i].qs2 == TAG_NONE;
        end
    end

`ifdef RS_AGE_SELECT_EN
    logic [DEPTH-1:0][DEPTH-1:0] age_q, age_d, low_age;
    // A fixed "lower index is older" matrix turns the age picker into a free-slot finder.
    always_comb begin
        for (int j = 0; j < DEPTH; j++)
            for (int i = 0; i < DEPTH; i++)
                low_age[j][i] = (j < i);
    end
`endif

    rs_select #(.DEPTH(DEPTH)) u_free (
        .req (free_vec),
`ifdef RS_AGE_SELECT_EN
        .age (low_age),
`endif
        .gnt (free_gnt),
        .idx (free_idx)
    );

    rs_select #(.DEPTH(DEPTH)) u_sel (
        .req (rdy_vec),
`ifdef RS_AGE_SELECT_EN
        .age (age_q),
`endif
        .gnt (sel_gnt),
        .idx (sel_idx)
    );

    assign bus.in_ready = en && (count_q != FULL);
    assign sel_any      = |sel_gnt;
    assign do_disp      = bus.in_valid && bus.in_ready && !flush && |free_gnt;
    assign do_load      = en && !flush && (!out_valid_q || bus.out_ready);

    always_comb begin
        nm1       = cdb_match(bus.in_qs1);
        nm2       = cdb_match(bus.in_qs2);
        new_e.op  = OP_W'(bus.in_op);
        new_e.pc  = DATA_W'(bus.in_pc);
        new_e.imm = DATA_W'(bus.in_imm);
        new_e.qd  = bus.in_qd;
        new_e.qs1 = nm1[DATA_W] ? TAG_NONE : bus.in_qs1;
        new_e.vs1 = nm1[DATA_W] ? nm1[DATA_W-1:0] : bus.in_vs1;
        new_e.qs2 = nm2[DATA_W] ? TAG_NONE : bus.in_qs2;
        new_e.vs2 = nm2[DATA_W] ? nm2[DATA_W-1:0] : bus.in_vs2;
        new_e.busy = 1'b1;
    end

    always_comb begin
        ent_d       = ent_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        count_d     = count_q;
        m1          = '0;
        m2          = '0;
`ifdef RS_AGE_SELECT_EN
        age_d       = age_q;
`endif
        if (en && flush) begin
            for (int i = 0; i < DEPTH; i++) ent_d[i].busy = 1'b0;
            out_valid_d = 1'b0;
            count_d     = '0;
        end else if (en) begin
            for (int i = 0; i < DEPTH; i++) begin
                m1 = cdb_match(ent_q[i].qs1);
                m2 = cdb_match(ent_q[i].qs2);
                if (m1[DATA_W]) begin
                    ent_d[i].qs1 = TAG_NONE;
                    ent_d[i].vs1 = m1[DATA_W-1:0];
                end
                if (m2[DATA_W]) begin
                    ent_d[i].qs2 = TAG_NONE;
                    ent_d[i].vs2 = m2[DATA_W-1:0];
                end
            end
            if (do_load) begin
                out_valid_d = sel_any;
                if (sel_any) begin
                    out_d = '{op: ent_q[sel_idx].op, pc: ent_q[sel_idx].pc, imm: ent_q[sel_idx].imm,
                              vs1: ent_q[sel_idx].vs1, vs2: ent_q[sel_idx].vs2, qd: ent_q[sel_idx].qd};
                    ent_d[sel_idx].busy = 1'b0;
                end
            end
            if (do_disp) begin
                ent_d[free_idx] = new_e;
`ifdef RS_AGE_SELECT_EN
                // Newcomer is younger than everything currently occupied.
                for (int j = 0; j < DEPTH; j++) begin
                    age_d[j][free_idx] = ent_q[j].busy && (j != int'(free_idx));
                    age_d[free_idx][j] = 1'b0;
                end
`endif
            end
            count_d = count_q + CW'(do_disp) - CW'(do_load && sel_any);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            count_q     <= '0;
`ifdef RS_AGE_SELECT_EN
            age_q       <= '0;
`endif
        end else begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            count_q     <= count_d;
`ifdef RS_AGE_SELECT_EN
            age_q       <= age_d;
`endif
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_op    = out_q.op;
    assign bus.out_pc    = out_q.pc;
    assign bus.out_imm   = out_q.imm;
    assign bus.out_vs1   = out_q.vs1;
    assign bus.out_vs2   = out_q.vs2;
    assign bus.out_qd    = out_q.qd;
    assign count         = count_q;
endmodule

// File: tb/tb_rs_multi_cdb.sv
// Directed bench for rs_multi_cdb: reset, dispatch/issue, CDB wakeup, bypass, full, age, flush.
module tb_rs_multi_cdb;
    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       flush;
    logic [4:0] count;
    int         checks = 0;
    int         fails  = 0;

    rs_multi_cdb_if #(.DATA_W(32), .TAG_W(5), .OP_W(6), .CDB_N(2)) bus ();

    rs_multi_cdb #(.DEPTH(16), .DATA_W(32), .TAG_W(5), .OP_W(6), .CDB_N(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .flush (flush),
        .bus   (bus),
        .count (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.cdb_valid = '0;
    endtask

    task automatic disp(input logic [4:0] qs1, input logic [4:0] qs2,
                        input logic [31:0] vs1, input logic [31:0] vs2, input logic [4:0] qd);
        bus.in_valid = 1'b1;
        bus.in_op    = 6'h3;
        bus.in_pc    = {25'd0, qd, 2'b00};
        bus.in_imm   = 32'h0;
        bus.in_qs1   = qs1;
        bus.in_qs2   = qs2;
        bus.in_vs1   = vs1;
        bus.in_vs2   = vs2;
        bus.in_qd    = qd;
    endtask

    task automatic cdb(input logic [1:0] v, input logic [4:0] t0, input logic [31:0] d0,
                       input logic [4:0] t1, input logic [31:0] d1);
        bus.cdb_valid = v;
        bus.cdb_tag   = {t1, t0};
        bus.cdb_data  = {d1, d0};
    endtask

    initial begin
        rst = 1'b0; en = 1'b1; flush = 1'b0;
        bus.out_ready = 1'b0;
        disp(0, 0, 0, 0, 0);
        idle();
        cdb(2'b00, 0, 0, 0, 0);
        #2;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_out_qd", bus.out_qd, 0);
        chk("rst_out_vs1", bus.out_vs1, 0);
        #1 rst = 1'b1;

        // en low: no dispatch, in_ready low
        tick();
        en = 1'b0;
        disp(0, 0, 32'h5, 0, 5'd50);
        #1;
        chk("en_low_in_ready", bus.in_ready, 0);
        tick();
        chk("en_low_count", count, 0);
        en = 1'b1;
        idle();

        // back-to-back ready dispatch
        bus.out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            disp(0, 0, 32'(k * 16), 32'(k), 5'(k));
            tick();
            chk("b2b_count", count, 1);
            chk("b2b_out_valid", bus.out_valid, (k > 1) ? 1 : 0);
            if (k > 1) chk("b2b_qd", bus.out_qd, k - 1);
        end
        idle();
        tick();
        chk("b2b_qd4", bus.out_qd, 4);
        chk("b2b_vs1_4", bus.out_vs1, 32'h40);
        chk("b2b_count_end", count, 0);
        tick();
        chk("b2b_drained", bus.out_valid, 0);

        // dual-CDB wakeup
        disp(5'd3, 5'd7, 32'hdead, 32'hdead, 5'd5);
        tick();
        idle();
        cdb(2'b11, 5'd3, 32'h11, 5'd7, 32'h22);
        tick();
        chk("dual_not_yet", bus.out_valid, 0);
        idle();
        tick();
        chk("dual_valid", bus.out_valid, 1);
        chk("dual_vs1", bus.out_vs1, 32'h11);
        chk("dual_vs2", bus.out_vs2, 32'h22);
        chk("dual_qd", bus.out_qd, 5);
        tick();

        // same tag on both ports: port 0 wins
        disp(5'd4, 0, 0, 32'h55, 5'd6);
        tick();
        idle();
        cdb(2'b11, 5'd4, 32'h33, 5'd4, 32'h44);
        tick();
        idle();
        tick();
        chk("prio_vs1", bus.out_vs1, 32'h33);
        chk("prio_vs2", bus.out_vs2, 32'h55);
        tick();

        // dispatch-time bypass
        disp(5'd5, 0, 32'h0, 32'h1, 5'd8);
        cdb(2'b10, 0, 0, 5'd5, 32'hAB);
        tick();
        idle();
        tick();
        chk("byp_valid", bus.out_valid, 1);
        chk("byp_vs1", bus.out_vs1, 32'hAB);
        chk("byp_qd", bus.out_qd, 8);
        tick();
        chk("byp_drained", bus.out_valid, 0);

        // fill to DEPTH with unready entries
        bus.out_ready = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            disp(5'd9, 0, 0, 0, 5'(k));
            tick();
        end
        chk("full_count", count, 16);
        chk("full_in_ready", bus.in_ready, 0);
        disp(0, 0, 0, 0, 5'd20);
        tick();
        chk("full_extra_ignored", count, 16);
        idle();
        cdb(2'b01, 5'd9, 32'h99, 0, 0);
        tick();
        idle();
        bus.out_ready = 1'b1;
        #1;
        chk("full_issue_no_reopen", bus.in_ready, 0);
        tick();
        chk("full_first_qd", bus.out_qd, 1);
        chk("full_first_vs1", bus.out_vs1, 32'h99);
        chk("full_count15", count, 15);
        for (int k = 2; k <= 16; k++) tick();
        chk("full_last_qd", bus.out_qd, 16);
        tick();
        chk("full_drain_valid", bus.out_valid, 0);
        chk("full_drain_count", count, 0);

        // age order: A lands in slot 2, later B in slot 0
        disp(5'd10, 0, 0, 0, 5'd1); tick();
        disp(5'd11, 0, 0, 0, 5'd2); tick();
        disp(5'd12, 0, 0, 0, 5'd3); tick();
        idle();
        cdb(2'b01, 5'd12, 32'h0, 0, 0); tick();
        idle(); tick();
        chk("age_setup_qd3", bus.out_qd, 3);
        disp(5'd13, 0, 32'hA, 0, 5'd21); tick();
        idle();
        cdb(2'b01, 5'd10, 32'h0, 0, 0); tick();
        idle(); tick();
        chk("age_setup_qd1", bus.out_qd, 1);
        disp(5'd13, 0, 32'hB, 0, 5'd22); tick();
        idle();
        cdb(2'b01, 5'd13, 32'h5, 0, 0); tick();
        idle(); tick();
`ifdef RS_AGE_SELECT_EN
        chk("age_first", bus.out_qd, 21);
        tick();
        chk("age_second", bus.out_qd, 22);
`else
        chk("age_first", bus.out_qd, 22);
        tick();
        chk("age_second", bus.out_qd, 21);
`endif
        chk("age_count", count, 1);
        tick();

        // backpressure then flush
        bus.out_ready = 1'b0;
        disp(0, 0, 32'h77, 0, 5'd30); tick();
        chk("bp_count_a", count, 2);
        disp(0, 0, 32'h78, 0, 5'd31); tick();
        chk("bp_valid", bus.out_valid, 1);
        chk("bp_qd", bus.out_qd, 30);
        idle(); tick();
        chk("bp_hold_qd", bus.out_qd, 30);
        chk("bp_hold_vs1", bus.out_vs1, 32'h77);
        chk("bp_count_b", count, 2);
        flush = 1'b1;
        disp(0, 0, 0, 0, 5'd32);
        tick();
        flush = 1'b0;
        idle();
        chk("flush_valid", bus.out_valid, 0);
        chk("flush_count", count, 0);
        tick();
        chk("flush_drop_disp", count, 0);
        chk("flush_valid2", bus.out_valid, 0);

        // asynchronous reset mid-operation
        for (int k = 0; k < 4; k++) begin
            disp(0, 0, 0, 0, 5'(40 + k));
            tick();
        end
        idle();
        chk("mid_count", count, 3);
        chk("mid_valid", bus.out_valid, 1);
        #3 rst = 1'b0;
        #1;
        chk("async_rst_valid", bus.out_valid, 0);
        chk("async_rst_count", count, 0);
        chk("async_rst_qd", bus.out_qd, 0);
        #1 rst = 1'b1;
        tick();
        chk("post_rst_count", count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
